allocator_6_80: RTL and testbench
=================================

# allocator_6_80

Output-port allocator for one output of the 6-input switch crossbar. Performs round-robin arbitration among the six input ports requesting this output, holds the grant for the whole wormhole packet (head through tail flit), and drives the registered one-hot `mux_sel` consumed by the crossbar multiplexer of the same output. It also generates the per-input flit acknowledge and the output valid for the downstream link.

## Interface

- `N_IN`: default 6. Number of input ports. Fixed at 6 for this switch.
- `clock` input 1: switch clock. All state updates on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `req` input 6: bit i is high while input i presents a valid flit routed to this output.
- `tail` input 6: bit i is high when input i's presented flit is a tail flit. Only meaningful when `req[i]` is high.
- `out_ready` input 1: the downstream buffer accepts a flit this cycle.
- `mux_sel` output 6: registered select for the crossbar mux. Either all-zero or exactly one-hot; bit i selects input i.
- `out_valid` output 1: a flit is presented on the crossbar output this cycle.
- `in_ack` output 6: one-hot acknowledge to the granted input when its flit is transferred this cycle.

## Operation

- State:
  - `grant` register (6-bit one-hot or zero), driven directly onto `mux_sel`.
  - `ptr` register (0..5), the round-robin priority pointer.
- States:
  - FREE when `grant == 0`.
  - LOCKED(g) when `grant[g] == 1`.
- Transfer condition: `xfer = LOCKED(g) & req[g] & out_ready`.
- Combinational outputs:
  - `out_valid = LOCKED(g) & req[g]`.
  - `in_ack = grant & {6{xfer}}`.
- Arbitration is enabled when FREE, or when LOCKED(g) with `xfer & tail[g]` (release cycle).
  - Winner: the first i with `req[i]` high, scanning from `ptr` upward modulo 6.
  - On release, the releasing input g is removed from the candidate set.
  - If there is a winner w: next `grant = 1 << w` and next `ptr = (w+1) mod 6`.
  - If there is no winner: next `grant = 0` and `ptr` is unchanged.
- LOCKED(g) without a tail transfer keeps `grant` and `ptr` unchanged. This holds even if `req[g]` drops or `out_ready` is low (wormhole hold).
- Requests from inputs other than g while LOCKED(g) are ignored until release.
- Single-flit packet (head is also tail): granted, transferred, and released like any other packet.
- `mux_sel` must never have more than one bit set. The crossbar mux outputs zero on an all-zero select.
- Reset values: `grant = 0`, `mux_sel = 0`, `ptr = 0`, `out_valid = 0`, `in_ack = 0`.
- Reset asserted mid-packet:
  - Grant drops immediately (asynchronously) and no partial-packet state is retained.
  - After reset deasserts, the next arbitration starts from `ptr = 0`.

## Timing

- Request to grant: `req[i]` sampled high in cycle N while FREE gives `mux_sel` one-hot i from cycle N+1. Earliest flit transfer is in cycle N+1.
- `out_valid` and `in_ack` are combinational from `req`, `out_ready` and the registered `grant`. There is no added latency on transfers while locked.
- Back-to-back packets:
  - A tail transfer in cycle M with a competing request pending gives a new grant in cycle M+1, with no bubble cycle.
  - If no request is pending, `mux_sel = 0` in cycle M+1.
- Re-grant to the same input after its tail is possible only when no other input requests. It is then taken at the M+1 edge.
- Fairness: with all six inputs requesting continuously, each input is granted exactly once every six packets.

## Test plan

- Reset: assert `reset` asynchronously mid-cycle while LOCKED(3) -> `mux_sel = 000000` and `out_valid = 0` immediately. Apply `req = 000100` after release -> `mux_sel = 000100` next cycle and `ptr = 3`.
- Single request, 4-flit packet: `req = 000010`, `out_ready = 1`, `tail` high on the 4th flit -> `mux_sel = 000010` from cycle 1. `in_ack[1]` high for 4 cycles. `mux_sel = 0` after the tail.
- Round-robin: `req = 111111` held, every packet 2 flits -> grant order 0,1,2,3,4,5,0, with no idle cycle between packets.
- Wormhole hold: LOCKED(2); drop `req[2]` for 3 cycles while `req[5]` is high -> `mux_sel` stays `000100`, `out_valid = 0`, `in_ack = 0`. Restoring `req[2]` resumes the transfer.
- Backpressure: LOCKED(4), `out_ready = 0` for 5 cycles with the tail presented -> `out_valid = 1`, `in_ack = 0`, no release. Tail transfers on the first `out_ready = 1` cycle.
- Single-flit packets plus release exclusion: `req = 000011` with `tail = 000011` and `ptr = 0` -> grants 0 then 1 on consecutive cycles. Input 0 is not re-granted on its own release cycle.

Source files
------------

// File: rtl/allocator_6_80.sv
// Output-port allocator for one crossbar output: round-robin arbitration among the
// inputs, grant held for a whole wormhole packet, registered one-hot mux select.
module allocator_6_80 #(
  parameter int N_IN = 6
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N_IN-1:0] req,
  input  logic [N_IN-1:0] tail,
  input  logic            out_ready,
  output logic [N_IN-1:0] mux_sel,
  output logic            out_valid,
  output logic [N_IN-1:0] in_ack
);

  localparam int PW = $clog2(N_IN);

  logic [N_IN-1:0] grant_q, grant_d;
  logic [PW-1:0]   ptr_q, ptr_d;

  logic            locked;
  logic            gnt_req;
  logic            xfer;
  logic            release_now;
  logic            arb_en;
  logic [N_IN-1:0] cand;

  assign locked      = |grant_q;
  assign gnt_req     = |(grant_q & req);
  assign xfer        = gnt_req & out_ready;
  assign release_now = xfer & |(grant_q & tail);
  assign arb_en      = ~locked | release_now;
  // Masking with the current grant drops the releasing input; when free it is a no-op.
  assign cand        = req & ~grant_q;

  assign mux_sel   = grant_q;
  assign out_valid = gnt_req;
  assign in_ack    = grant_q & {N_IN{xfer}};

  always_comb begin
    logic          found;
    logic [PW-1:0] idx;
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    grant_d = grant_q;
    ptr_d   = ptr_q;
    found   = 1'b0;
    idx     = '0;
    if (arb_en) begin
      grant_d = '0;
      for (int off = 0; off < N_IN; off++) begin
        idx = PW'((int'(ptr_q) + off) % N_IN);
        if (!found && cand[idx]) begin
          found        = 1'b1;
          grant_d[idx] = 1'b1;
          ptr_d        = (idx == PW'(N_IN - 1)) ? '0 : idx + 1'b1;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_allocator_6_80.sv
// Directed bench for allocator_6_80: the driver queues hand-computed expected outputs
// per cycle, and an independent monitor compares them on the falling edge.
module tb_allocator_6_80;

  logic       clock;
  logic       reset;
  logic [5:0] req;
  logic [5:0] tail;
  logic       out_ready;
  logic [5:0] mux_sel;
  logic       out_valid;
  logic [5:0] in_ack;

  typedef struct {
    string      name;
    logic [5:0] sel;
    logic       val;
    logic [5:0] ack;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  allocator_6_80 dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .tail      (tail),
    .out_ready (out_ready),
    .mux_sel   (mux_sel),
    .out_valid (out_valid),
    .in_ack    (in_ack)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge and queue what must be seen.
  task automatic step(input string name, input logic [5:0] r, input logic [5:0] t,
                      input logic rdy, input logic [5:0] e_sel, input logic e_val,
                      input logic [5:0] e_ack);
    exp_t e;
    @(posedge clock);
    #1;
    req       = r;
    tail      = t;
    out_ready = rdy;
    e.name = name;
    e.sel  = e_sel;
    e.val  = e_val;
    e.ack  = e_ack;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.name, ".mux_sel"},   32'(mux_sel),   32'(e.sel));
        check({e.name, ".out_valid"}, 32'(out_valid), 32'(e.val));
        check({e.name, ".in_ack"},    32'(in_ack),    32'(e.ack));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin : driver
    int g;
    reset     = 1'b1;
    req       = '0;
    tail      = '0;
    out_ready = 1'b0;
    #12 reset = 1'b0;

    step("reset_state", 6'b000000, 6'b000000, 1'b1, 6'b000000, 1'b0, 6'b000000);

    // Single-flit packets on inputs 0 and 1 from ptr=0, then release exclusion of input 0.
    step("sf_req",      6'b000011, 6'b000011, 1'b1, 6'b000000, 1'b0, 6'b000000);
    step("sf_g0",       6'b000011, 6'b000011, 1'b1, 6'b000001, 1'b1, 6'b000001);
    step("sf_g1",       6'b000011, 6'b000011, 1'b1, 6'b000010, 1'b1, 6'b000010);
    step("sf_g0b",      6'b000001, 6'b000001, 1'b1, 6'b000001, 1'b1, 6'b000001);
    step("sf_excl",     6'b000001, 6'b000001, 1'b1, 6'b000000, 1'b0, 6'b000000);
    step("sf_g0c",      6'b000001, 6'b000001, 1'b1, 6'b000001, 1'b1, 6'b000001);
    step("sf_idle",     6'b000000, 6'b000000, 1'b1, 6'b000000, 1'b0, 6'b000000);

    // Four-flit packet on input 1.
    step("p4_req",      6'b000010, 6'b000000, 1'b1, 6'b000000, 1'b0, 6'b000000);
    step("p4_f1",       6'b000010, 6'b000000, 1'b1, 6'b000010, 1'b1, 6'b000010);
    step("p4_f2",       6'b000010, 6'b000000, 1'b1, 6'b000010, 1'b1, 6'b000010);
    step("p4_f3",       6'b000010, 6'b000000, 1'b1, 6'b000010, 1'b1, 6'b000010);
    step("p4_f4",       6'b000010, 6'b000010, 1'b1, 6'b000010, 1'b1, 6'b000010);
    step("p4_done",     6'b000000, 6'b000000, 1'b1, 6'b000000, 1'b0, 6'b000000);

    // Lock input 3, then assert reset in the middle of a cycle.
    step("rst_req3",    6'b001000, 6'b000000, 1'b1, 6'b000000, 1'b0, 6'b000000);
    step("rst_lock3",   6'b001000, 6'b000000, 1'b1, 6'b001000, 1'b1, 6'b001000);
    step("rst_async",   6'b001000, 6'b000000, 1'b1, 6'b000000, 1'b0, 6'b000000);
    #2 reset = 1'b1;
    step("rst_hold",    6'b000000, 6'b000000, 1'b1, 6'b000000, 1'b0, 6'b000000);
    #2 reset = 1'b0;
    step("rst_req2",    6'b000100, 6'b000000, 1'b1, 6'b000000, 1'b0, 6'b000000);
    step("rst_g2",      6'b000100, 6'b000000, 1'b1, 6'b000100, 1'b1, 6'b000100);

    // Wormhole hold on input 2 while input 5 requests.
    step("hold_1",      6'b100000, 6'b000000, 1'b1, 6'b000100, 1'b0, 6'b000000);
    step("hold_2",      6'b100000, 6'b000000, 1'b1, 6'b000100, 1'b0, 6'b000000);
    step("hold_3",      6'b100000, 6'b000000, 1'b1, 6'b000100, 1'b0, 6'b000000);
    step("hold_resume", 6'b100100, 6'b000000, 1'b1, 6'b000100, 1'b1, 6'b000100);
    step("hold_tail",   6'b100100, 6'b000100, 1'b1, 6'b000100, 1'b1, 6'b000100);

    // Input 5 finishes, input 4 is granted with no bubble, then backpressure on its tail.
    step("bp_g5",       6'b110000, 6'b100000, 1'b1, 6'b100000, 1'b1, 6'b100000);
    for (int i = 0; i < 5; i++)
      step("bp_stall",  6'b010000, 6'b010000, 1'b0, 6'b010000, 1'b1, 6'b000000);
    step("bp_tail",     6'b010000, 6'b010000, 1'b1, 6'b010000, 1'b1, 6'b010000);
    // ptr is now 5, so input 5 wins over input 0.
    step("ptr5_req",    6'b100001, 6'b100001, 1'b1, 6'b000000, 1'b0, 6'b000000);
    step("ptr5_g5",     6'b100001, 6'b100001, 1'b1, 6'b100000, 1'b1, 6'b100000);
    step("ptr5_g0",     6'b000001, 6'b000001, 1'b1, 6'b000001, 1'b1, 6'b000001);
    step("ptr5_idle",   6'b000000, 6'b000000, 1'b1, 6'b000000, 1'b0, 6'b000000);
    #1 reset = 1'b1;
    #2 reset = 1'b0;

    // Round-robin fairness with all inputs requesting, two flits per packet.
    step("rr_req",      6'b111111, 6'b000000, 1'b1, 6'b000000, 1'b0, 6'b000000);
    for (int k = 0; k < 7; k++) begin
      g = k % 6;
      step("rr_head",   6'b111111, 6'b000000, 1'b1, 6'(1 << g), 1'b1, 6'(1 << g));
      step("rr_tail",   6'b111111, 6'b111111, 1'b1, 6'(1 << g), 1'b1, 6'(1 << g));
    end
    step("rr_g1_wait",  6'b000000, 6'b000000, 1'b1, 6'b000010, 1'b0, 6'b000000);
    step("rr_g1_tail",  6'b000010, 6'b000010, 1'b1, 6'b000010, 1'b1, 6'b000010);
    step("rr_idle",     6'b000000, 6'b000000, 1'b1, 6'b000000, 1'b0, 6'b000000);

    @(negedge clock);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
